// File: rtl/cpu_run_ctrl.sv
// Run controller for the single-cycle RV32 core: sequences the core reset, counts run
// cycles and ends the run on a TOHOST store, a PC self-loop halt or a cycle timeout.
// Optional feature macro: CPU_RUN_CTRL_SIG_EN (rolling signature over RUN-state stores).
module cpu_run_ctrl #(
  parameter int unsigned     XLEN        = 32,
  parameter int unsigned     RST_CYCLES  = 4,
  parameter int unsigned     HALT_CYCLES = 8,
  parameter int unsigned     MAX_CYCLES  = 1000,
  parameter int unsigned     CNT_W       = 32,
  parameter logic [XLEN-1:0] TOHOST_ADDR = 32'h0000_0FFC
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [XLEN-1:0]  pc,
  input  logic             dmem_we,
  input  logic [XLEN-1:0]  dmem_addr,
  input  logic [XLEN-1:0]  dmem_wdata,
  output logic             cpu_rst,
  output logic             running,
  output logic             run_done,
  output logic             run_pass,
  output logic             run_timeout,
  output logic [XLEN-1:0]  fail_code,
  output logic [CNT_W-1:0] cycle_count,
  output logic [XLEN-1:0]  signature
);

  localparam int unsigned HoldW = $clog2(RST_CYCLES + 1);
  localparam int unsigned HaltW = $clog2(HALT_CYCLES + 1);

  typedef enum logic [1:0] {StHold, StRun, StDone} state_e;

  state_e            state_q, state_d;
  logic [HoldW-1:0]  hold_cnt_q, hold_cnt_d;
  logic [HaltW-1:0]  halt_cnt_q, halt_cnt_d;
  logic              cpu_rst_q, cpu_rst_d;
  logic              pass_q, pass_d;
  logic              timeout_q, timeout_d;
  logic [XLEN-1:0]   fail_code_q, fail_code_d;
  logic [CNT_W-1:0]  cycle_cnt_q, cycle_cnt_d;
  logic [XLEN-1:0]   prev_pc_q;

  logic tohost_hit, pc_same, halt_hit, timeout_hit;

  // Termination detectors; a zero TOHOST store is not a report and is ignored.
  assign tohost_hit  = dmem_we && (dmem_addr == TOHOST_ADDR) && (dmem_wdata != '0);
  assign pc_same     = (pc == prev_pc_q);
  // The equal-pc count would reach HALT_CYCLES-1 on this edge.
  assign halt_hit    = pc_same && (halt_cnt_q == HaltW'(HALT_CYCLES - 2));
  assign timeout_hit = (cycle_cnt_q == CNT_W'(MAX_CYCLES - 1));

  // Next-state logic for the HOLD -> RUN -> DONE sequence and the sticky result flags.
  always_comb begin
    state_d     = state_q;
    hold_cnt_d  = hold_cnt_q;
    halt_cnt_d  = halt_cnt_q;
    cpu_rst_d   = cpu_rst_q;
    pass_d      = pass_q;
    timeout_d   = timeout_q;
    fail_code_d = fail_code_q;
    cycle_cnt_d = cycle_cnt_q;
    unique case (state_q)
      StHold: begin
        halt_cnt_d = '0;
        if (hold_cnt_q == HoldW'(RST_CYCLES - 1)) begin
          state_d   = StRun;
          cpu_rst_d = 1'b1;
        end else begin
          hold_cnt_d = HoldW'(hold_cnt_q + 1'b1);
        end
      end
      StRun: begin
        if (cycle_cnt_q != '1) cycle_cnt_d = cycle_cnt_q + 1'b1;
        halt_cnt_d = pc_same ? HaltW'(halt_cnt_q + 1'b1) : '0;
        // Priority: TOHOST report, then halt, then timeout; only one outcome recorded.
        if (tohost_hit) begin
          state_d     = StDone;
          pass_d      = (dmem_wdata == XLEN'(1));
          fail_code_d = (dmem_wdata == XLEN'(1)) ? '0 : (dmem_wdata >> 1);
        end else if (halt_hit) begin
          state_d = StDone;
        end else if (timeout_hit) begin
          state_d   = StDone;
          timeout_d = 1'b1;
        end
      end
      StDone: ;
      default: state_d = StHold;
    endcase
  end

  // State and result registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q     <= StHold;
      hold_cnt_q  <= '0;
      halt_cnt_q  <= '0;
      cpu_rst_q   <= 1'b0;
      pass_q      <= 1'b0;
      timeout_q   <= 1'b0;
      fail_code_q <= '0;
      cycle_cnt_q <= '0;
      prev_pc_q   <= '0;
    end else begin
      state_q     <= state_d;
      hold_cnt_q  <= hold_cnt_d;
      halt_cnt_q  <= halt_cnt_d;
      cpu_rst_q   <= cpu_rst_d;
      pass_q      <= pass_d;
      timeout_q   <= timeout_d;
      fail_code_q <= fail_code_d;
      cycle_cnt_q <= cycle_cnt_d;
      prev_pc_q   <= pc;
    end
  end

`ifdef CPU_RUN_CTRL_SIG_EN
  logic [XLEN-1:0] sig_q, sig_d;

  // Rotate-left-and-fold every store seen while running, including TOHOST.
  always_comb begin
    sig_d = sig_q;
    if (state_q == StRun && dmem_we) begin
      sig_d = {sig_q[XLEN-2:0], sig_q[XLEN-1]} ^ dmem_wdata ^ dmem_addr;
    end
  end

  // Signature register.
  always_ff @(posedge clk) begin
    if (!rst) sig_q <= '0;
    else      sig_q <= sig_d;
  end

  assign signature = sig_q;
`else
  assign signature = '0;
`endif

  assign cpu_rst     = cpu_rst_q;
  assign running     = (state_q == StRun);
  assign run_done    = (state_q == StDone);
  assign run_pass    = pass_q;
  assign run_timeout = timeout_q;
  assign fail_code   = fail_code_q;
  assign cycle_count = cycle_cnt_q;

endmodule

// File: tb/tb_cpu_run_ctrl.sv
// Directed testbench for cpu_run_ctrl: reset sequencing, pass/fail reports, halt,
// timeout, termination priority and mid-run reset.
module tb_cpu_run_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [31:0] pc = '0;
  logic        dmem_we = 1'b0;
  logic [31:0] dmem_addr = '0;
  logic [31:0] dmem_wdata = '0;
  logic        cpu_rst, running, run_done, run_pass, run_timeout;
  logic [31:0] fail_code, cycle_count, signature;

  int n_checks = 0;
  int n_err    = 0;

  cpu_run_ctrl #(
    .MAX_CYCLES(50)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .pc         (pc),
    .dmem_we    (dmem_we),
    .dmem_addr  (dmem_addr),
    .dmem_wdata (dmem_wdata),
    .cpu_rst    (cpu_rst),
    .running    (running),
    .run_done   (run_done),
    .run_pass   (run_pass),
    .run_timeout(run_timeout),
    .fail_code  (fail_code),
    .cycle_count(cycle_count),
    .signature  (signature)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp)
    else begin
      n_err++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Outputs are sampled 1 time unit after the rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic run_n(input int n);
    for (int i = 0; i < n; i++) begin
      pc = pc + 32'd4;
      tick();
    end
  endtask

  task automatic store(input logic [31:0] addr, input logic [31:0] data);
    dmem_we    = 1'b1;
    dmem_addr  = addr;
    dmem_wdata = data;
    pc         = pc + 32'd4;
    tick();
    dmem_we    = 1'b0;
  endtask

  task automatic do_reset();
    rst     = 1'b0;
    dmem_we = 1'b0;
    tick();
    chk("rst_cpu_rst", cpu_rst, 0);
    chk("rst_done", run_done, 0);
    chk("rst_count", cycle_count, 0);
    rst = 1'b1;
    repeat (4) tick();
    chk("rel_running", running, 1);
  endtask

  logic [31:0] sig_exp;

  initial begin
    // Reset held 3 cycles, then release takes exactly 4 edges.
    repeat (3) tick();
    chk("reset_cpu_rst", cpu_rst, 0);
    chk("reset_running", running, 0);
    chk("reset_done", run_done, 0);
    chk("reset_pass", run_pass, 0);
    chk("reset_timeout", run_timeout, 0);
    chk("reset_count", cycle_count, 0);
    chk("reset_fail", fail_code, 0);
    rst = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      tick();
      chk($sformatf("release_edge%0d", i), cpu_rst, (i == 4));
    end
    chk("run_running", running, 1);
    chk("run_count0", cycle_count, 0);

    // Pass report at run cycle 20.
    run_n(20);
    chk("pass_pre_count", cycle_count, 20);
    store(32'h0FFC, 32'd1);
    chk("pass_done", run_done, 1);
    chk("pass_pass", run_pass, 1);
    chk("pass_count", cycle_count, 21);
    chk("pass_running", running, 0);
    chk("pass_cpu_rst", cpu_rst, 1);
    chk("pass_timeout", run_timeout, 0);
    run_n(3);
    chk("pass_frozen_count", cycle_count, 21);
    chk("pass_frozen_done", run_done, 1);

    // Fail report; zero store ignored beforehand, pass store ignored afterwards.
    do_reset();
    run_n(5);
    store(32'h0FFC, 32'd0);
    chk("zero_store_running", running, 1);
    store(32'h0FFC, 32'd7);
    chk("fail_done", run_done, 1);
    chk("fail_pass", run_pass, 0);
    chk("fail_code", fail_code, 3);
    chk("fail_timeout", run_timeout, 0);
    store(32'h0FFC, 32'd1);
    chk("fail_late_pass", run_pass, 0);
    chk("fail_late_code", fail_code, 3);

    // Signature store, then reset mid-run.
    do_reset();
    run_n(3);
    store(32'h0100, 32'h10);
`ifdef CPU_RUN_CTRL_SIG_EN
    sig_exp = 32'h110;
`else
    sig_exp = 32'h0;
`endif
    chk("sig_value", signature, sig_exp);
    chk("sig_running", running, 1);
    rst = 1'b0;
    tick();
    chk("midrst_cpu_rst", cpu_rst, 0);
    chk("midrst_running", running, 0);
    chk("midrst_count", cycle_count, 0);
    chk("midrst_sig", signature, 0);
    chk("midrst_done", run_done, 0);
    rst = 1'b1;
    repeat (3) tick();
    chk("midrst_hold", cpu_rst, 0);
    tick();
    chk("midrst_rel", running, 1);

    // Halt: 7 equal cycles then change is not a halt; 8 equal cycles is.
    pc = 32'h200;
    tick();
    pc = 32'h80;
    repeat (7) tick();
    pc = 32'h84;
    tick();
    chk("halt7_running", running, 1);
    chk("halt7_done", run_done, 0);
    pc = 32'h40;
    repeat (7) tick();
    chk("halt8_pre", running, 1);
    tick();
    chk("halt_done", run_done, 1);
    chk("halt_pass", run_pass, 0);
    chk("halt_timeout", run_timeout, 0);
    chk("halt_fail", fail_code, 0);

    // Timeout after 50 RUN cycles.
    do_reset();
    run_n(49);
    chk("to_pre_running", running, 1);
    chk("to_pre_count", cycle_count, 49);
    run_n(1);
    chk("to_done", run_done, 1);
    chk("to_timeout", run_timeout, 1);
    chk("to_count", cycle_count, 50);
    chk("to_pass", run_pass, 0);

    // TOHOST pass in the timeout cycle wins.
    do_reset();
    run_n(49);
    store(32'h0FFC, 32'd1);
    chk("prio_done", run_done, 1);
    chk("prio_pass", run_pass, 1);
    chk("prio_timeout", run_timeout, 0);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
